sparc_window_regfile: RTL and testbench
=======================================

# sparc_window_regfile

SPARC V8 windowed integer register file with current-window-pointer (CWP) management and window overflow/underflow detection. It sits directly upstream of the operand-select multiplexers in the datapath. Each cycle it presents the two source operands addressed by the instruction as 32-bit words, and it accepts one destination write. It maps the 5-bit architectural register number through CWP onto a physical array of `8 + 16*NWIN` registers and executes SAVE/RESTORE window rotation checked against WIM.

## Interface
- `NWIN`, 4: number of register windows, 2..32; CWP width is `CW = clog2(NWIN)` (minimum 1).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `rs1`, `rs2` input 5 each: architectural source register numbers.
- `rd` input 5: architectural destination register number.
- `wdata` input 32: write data.
- `we` input 1: write enable for `rd`.
- `save` input 1: SAVE request; rotates to window `(CWP-1) mod NWIN`.
- `restore` input 1: RESTORE request; rotates to window `(CWP+1) mod NWIN`.
- `cwp_ld` input 1: direct CWP load, used by WRPSR.
- `cwp_in` input CW: value loaded on `cwp_ld`.
- `wim` input NWIN: window invalid mask; bit w=1 marks window w invalid.
- `rdata1`, `rdata2` output 32 each: combinational read data for `rs1`/`rs2`.
- `cwp` output CW: current window pointer.
- `wovf` output 1: window overflow trap, registered one-cycle pulse.
- `wunf` output 1: window underflow trap, registered one-cycle pulse.

## Operation
- Physical map: P[0..7] are the globals, with P[0] hardwired to 0. Window w owns P[8+16w .. 8+16w+7] (outs, r8–r15) and P[8+16w+8 .. 8+16w+15] (locals, r16–r23).
- The ins (r24–r31) of window w are the outs of window `(w+1) mod NWIN`. Window w's ins therefore occupy P[8+16((w+1) mod NWIN) + (r-24)].
- r0 always reads 0. Writes to r0 are discarded.
- Reads are purely combinational from the array using the current `cwp`. There is no write-through: a value written at edge t becomes visible after edge t.
- Next-window computation: `nsave = (cwp-1) mod NWIN`, `nrest = (cwp+1) mod NWIN`. Wrap-around is required: 0-1 gives NWIN-1, and NWIN-1+1 gives 0.
- Command priority per cycle:
  - `cwp_ld`: CWP ← `cwp_in`. `save`/`restore` are ignored and no trap is raised.
  - Otherwise, `save` and `restore` both asserted: no CWP change and no trap.
  - Otherwise, `save` only:
    - If `wim[nsave]` = 1: `wovf` pulses and CWP is unchanged.
    - Else CWP ← `nsave`.
  - Otherwise, `restore` only:
    - If `wim[nrest]` = 1: `wunf` pulses and CWP is unchanged.
    - Else CWP ← `nrest`.
- Write window selection, matching SPARC SAVE/RESTORE semantics (sources from the old window, `rd` into the new one):
  - A successful save/restore in the same cycle decodes `rd` with the new window.
  - `cwp_ld` decodes with the old `cwp`.
  - In all other cases, including a trapped save/restore, `rd` is decoded with the current `cwp`.
- A trapped save/restore suppresses the write: no register changes even if `we` = 1.
- Globals (r1–r7) are shared across all windows and are independent of CWP.

## Timing
- Reset (`reset_n` low, asynchronous): all physical registers = 0, `cwp` = 0, `wovf` = 0, `wunf` = 0. State is held while low.
- If reset asserts during an operation in flight, that operation is lost. The first edge after release behaves normally.
- `rdata1`/`rdata2` have zero-cycle latency: combinational from `rs1`/`rs2`/`cwp`/array.
- CWP update, register write and trap flag are registered on the same rising edge.
- `wovf`/`wunf` are high for exactly the one cycle after the triggering edge. They deassert on the next edge unless retriggered.
- Back-to-back SAVEs on consecutive cycles are legal; each is evaluated against the `cwp` updated by the previous one.

## Test plan
- Reset, NWIN=4: assert `reset_n`=0 mid-cycle → `cwp`=0, `rdata1` for every rs1 = 0, `wovf`=`wunf`=0, with no clock edge required.
- Window overlap: at cwp=1, write r8 = 0xDEADBEEF; then `restore` with `wim`=0 → cwp=2. Return to cwp=1 and `save` → cwp=0. At cwp=0, read r24 → 0xDEADBEEF, since the outs of window 1 are the ins of window 0.
- Wrap and overflow: cwp=0, `wim`=4'b1000, `save` → `wovf`=1 for one cycle, cwp stays 0, and a simultaneous `we` to r16 leaves r16 unchanged. Repeat with `wim`=0 → cwp=3, no trap.
- Underflow and wrap: `cwp_ld` with `cwp_in`=3, `wim`=4'b0001, `restore` → `wunf` pulse, cwp stays 3. With `wim`=0 → cwp=0.
- SAVE write semantics: cwp=2, `save`, `we`=1, rd=r16, wdata=0x12345678 → after the edge cwp=1 and r16 reads 0x12345678. Window 2's r16 is unchanged; verify this after `restore`.
- Globals/r0: write r5 = 0xA5A5A5A5 and r0 = 0xFFFFFFFF at cwp=0, then `save` → r5 reads 0xA5A5A5A5 at cwp=3, r0 reads 0. `save`+`restore` together → no cwp change, no trap.

Source files
------------

// File: rtl/sparc_window_regfile.sv
// SPARC V8 windowed integer register file: maps r0..r31 through CWP onto a flat
// physical array of 8 globals plus 16 registers per window, and runs SAVE/RESTORE against WIM.
module sparc_window_regfile #(
    parameter  int NWIN = 4,
    localparam int CW   = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [31:0]     wdata,
    input  logic            we,
    input  logic            save,
    input  logic            restore,
    input  logic            cwp_ld,
    input  logic [CW-1:0]   cwp_in,
    input  logic [NWIN-1:0] wim,
    output logic [31:0]     rdata1,
    output logic [31:0]     rdata2,
    output logic [CW-1:0]   cwp,
    output logic            wovf,
    output logic            wunf
);

    localparam int NPHYS = 8 + 16 * NWIN;
    localparam int PW    = $clog2(NPHYS);

    logic [31:0]   regs_q [NPHYS];
    logic [31:0]   regs_d [NPHYS];
    logic [CW-1:0] cwp_q, cwp_d;
    logic          wovf_q, wovf_d;
    logic          wunf_q, wunf_d;

    logic [CW-1:0] nsave, nrest;
    logic [CW-1:0] wr_win;
    logic [PW-1:0] wr_idx;
    logic          trap;
    logic          wr_en;

    // The ins of window w are the outs of window w+1 (mod NWIN), so r24..r31
    // index into the next window's out block.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0] r, input logic [CW-1:0] w);
        int wi;
        int base;
        wi = int'(w);
        if (r < 5'd8) begin
            base = int'(r);
        end else if (r < 5'd24) begin
            base = 8 + 16 * wi + int'(r) - 8;
        end else begin
            wi   = (wi == NWIN - 1) ? 0 : wi + 1;
            base = 8 + 16 * wi + int'(r) - 24;
        end
        return PW'(base);
    endfunction

    assign rdata1 = (rs1 == 5'd0) ? 32'd0 : regs_q[phys_idx(rs1, cwp_q)];
    assign rdata2 = (rs2 == 5'd0) ? 32'd0 : regs_q[phys_idx(rs2, cwp_q)];
    assign cwp    = cwp_q;
    assign wovf   = wovf_q;
    assign wunf   = wunf_q;

    always_comb begin
        nsave  = (cwp_q == '0) ? CW'(NWIN - 1) : cwp_q - CW'(1);
        nrest  = (cwp_q == CW'(NWIN - 1)) ? '0 : cwp_q + CW'(1);
        cwp_d  = cwp_q;
        wovf_d = 1'b0;
        wunf_d = 1'b0;
        trap   = 1'b0;
        wr_win = cwp_q;

        // A successful rotation writes rd into the new window; cwp_ld and
        // trapped rotations decode rd with the window that was current.
        if (cwp_ld) begin
            cwp_d = cwp_in;
        end else if (save && restore) begin
            cwp_d = cwp_q;
        end else if (save) begin
            if (wim[nsave]) begin
                wovf_d = 1'b1;
                trap   = 1'b1;
            end else begin
                cwp_d  = nsave;
                wr_win = nsave;
            end
        end else if (restore) begin
            if (wim[nrest]) begin
                wunf_d = 1'b1;
                trap   = 1'b1;
            end else begin
                cwp_d  = nrest;
                wr_win = nrest;
            end
        end

        wr_en  = we && (rd != 5'd0) && !trap;
        wr_idx = phys_idx(rd, wr_win);
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_idx] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
            cwp_q  <= '0;
            wovf_q <= 1'b0;
            wunf_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cwp_q  <= cwp_d;
            wovf_q <= wovf_d;
            wunf_q <= wunf_d;
        end
    end

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Bench for sparc_window_regfile: directed window/trap scenarios then random traffic,
// compared against a window-structured reference model (globals, outs, locals per window).
module tb_sparc_window_regfile;

    localparam int NWIN = 4;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     wdata;
    logic            we, save, restore, cwp_ld;
    logic [CW-1:0]   cwp_in;
    logic [NWIN-1:0] wim;
    logic [31:0]     rdata1, rdata2;
    logic [CW-1:0]   cwp;
    logic            wovf, wunf;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [31:0] m_g    [8];
    logic [31:0] m_outs [NWIN][8];
    logic [31:0] m_locs [NWIN][8];
    int          mcwp;
    logic        mwovf, mwunf;

    sparc_window_regfile #(.NWIN(NWIN)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1(rs1), .rs2(rs2), .rd(rd), .wdata(wdata), .we(we),
        .save(save), .restore(restore), .cwp_ld(cwp_ld), .cwp_in(cwp_in), .wim(wim),
        .rdata1(rdata1), .rdata2(rdata2), .cwp(cwp), .wovf(wovf), .wunf(wunf)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_g[i] = '0;
        for (int w = 0; w < NWIN; w++)
            for (int i = 0; i < 8; i++) begin
                m_outs[w][i] = '0;
                m_locs[w][i] = '0;
            end
        mcwp  = 0;
        mwovf = 1'b0;
        mwunf = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(int w, int r);
        if (r == 0)      return 32'd0;
        else if (r < 8)  return m_g[r];
        else if (r < 16) return m_outs[w][r-8];
        else if (r < 24) return m_locs[w][r-16];
        else             return m_outs[(w+1) % NWIN][r-24];
    endfunction

    function automatic void model_write(int w, int r, logic [31:0] d);
        if (r == 0)      return;
        else if (r < 8)  m_g[r] = d;
        else if (r < 16) m_outs[w][r-8] = d;
        else if (r < 24) m_locs[w][r-16] = d;
        else             m_outs[(w+1) % NWIN][r-24] = d;
    endfunction

    function automatic void model_step(logic sv, logic rs, logic ld, int cin,
                                       logic [NWIN-1:0] wm, logic w, int r, logic [31:0] d);
        int  ns = (mcwp + NWIN - 1) % NWIN;
        int  nr = (mcwp + 1) % NWIN;
        int  ww = mcwp;
        bit  tr = 0;
        mwovf = 1'b0;
        mwunf = 1'b0;
        if (ld) mcwp = cin;
        else if (sv && rs) ;
        else if (sv) begin
            if (wm[ns]) begin mwovf = 1'b1; tr = 1; end
            else begin mcwp = ns; ww = ns; end
        end else if (rs) begin
            if (wm[nr]) begin mwunf = 1'b1; tr = 1; end
            else begin mcwp = nr; ww = nr; end
        end
        if (w && !tr) model_write(ww, r, d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic sv, input logic rs, input logic ld, input int cin,
                         input logic [NWIN-1:0] wm, input logic w, input int r,
                         input logic [31:0] d, input string tag);
        @(negedge clk);
        save = sv; restore = rs; cwp_ld = ld; cwp_in = CW'(cin);
        wim = wm; we = w; rd = 5'(r); wdata = d;
        model_step(sv, rs, ld, cin, wm, w, r, d);
        @(posedge clk);
        #1;
        save = 1'b0; restore = 1'b0; cwp_ld = 1'b0; we = 1'b0;
        chk({tag, ":cwp"},  32'(cwp),  32'(mcwp));
        chk({tag, ":wovf"}, 32'(wovf), 32'(mwovf));
        chk({tag, ":wunf"}, 32'(wunf), 32'(mwunf));
    endtask

    task automatic check_reg(input int r, input string tag);
        rs1 = 5'(r);
        rs2 = 5'(31 - r);
        #1;
        chk({tag, ":rd1"}, rdata1, model_read(mcwp, r));
        chk({tag, ":rd2"}, rdata2, model_read(mcwp, 31 - r));
    endtask

    task automatic check_const(input int r, input logic [31:0] exp, input string tag);
        rs1 = 5'(r);
        #1;
        chk(tag, rdata1, exp);
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            #1;
            chk($sformatf("%s:r%0d", tag, r), rdata1, 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        rs1 = '0; rs2 = '0; rd = '0; wdata = '0; we = 1'b0;
        save = 1'b0; restore = 1'b0; cwp_ld = 1'b0; cwp_in = '0; wim = '0;
        model_reset();

        // reset asserted mid-cycle, outputs checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("rst:cwp",  32'(cwp),  32'd0);
        chk("rst:wovf", 32'(wovf), 32'd0);
        chk("rst:wunf", 32'(wunf), 32'd0);
        check_all_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // window overlap: outs of window 1 are the ins of window 0
        cycle(0, 0, 1, 1, 4'b0000, 0, 0,  32'h0,        "ld1");
        cycle(0, 0, 0, 0, 4'b0000, 1, 8,  32'hDEADBEEF, "wr_r8");
        cycle(0, 1, 0, 0, 4'b0000, 0, 0,  32'h0,        "rest_to2");
        cycle(1, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "save_to1");
        cycle(1, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "save_to0");
        check_const(24, 32'hDEADBEEF, "overlap_r24");
        check_reg(24, "overlap_model");

        // overflow at cwp=0 with wim[3] set; write suppressed
        cycle(0, 0, 0, 0, 4'b0000, 1, 16, 32'h0BADF00D, "w0_r16");
        cycle(1, 0, 0, 0, 4'b1000, 1, 16, 32'h11111111, "ovf");
        check_const(16, 32'h0BADF00D, "ovf_r16_kept");
        cycle(0, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "ovf_clear");
        cycle(1, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "save_wrap3");
        chk("save_wrap3_const", 32'(cwp), 32'd3);

        // underflow at cwp=3 with wim[0] set, then wrap to 0
        cycle(0, 0, 1, 3, 4'b0000, 0, 0,  32'h0,        "ld3");
        cycle(0, 1, 0, 0, 4'b0001, 0, 0,  32'h0,        "unf");
        cycle(0, 1, 0, 0, 4'b0000, 0, 0,  32'h0,        "rest_wrap0");
        chk("rest_wrap0_const", 32'(cwp), 32'd0);

        // SAVE writes rd into the new window
        cycle(0, 0, 1, 2, 4'b0000, 0, 0,  32'h0,        "ld2");
        cycle(0, 0, 0, 0, 4'b0000, 1, 16, 32'hCAFE0002, "w2_r16");
        cycle(1, 0, 0, 0, 4'b0000, 1, 16, 32'h12345678, "save_wr");
        check_const(16, 32'h12345678, "save_wr_r16");
        cycle(0, 1, 0, 0, 4'b0000, 0, 0,  32'h0,        "rest_back2");
        check_const(16, 32'hCAFE0002, "win2_r16_kept");

        // globals shared across windows, r0 stays zero
        cycle(0, 0, 1, 0, 4'b0000, 0, 0,  32'h0,        "ld0");
        cycle(0, 0, 0, 0, 4'b0000, 1, 5,  32'hA5A5A5A5, "w_r5");
        cycle(0, 0, 0, 0, 4'b0000, 1, 0,  32'hFFFFFFFF, "w_r0");
        cycle(1, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "save_g");
        check_const(5, 32'hA5A5A5A5, "glob_r5");
        check_const(0, 32'h0,        "r0_zero");
        cycle(1, 1, 0, 0, 4'b1111, 0, 0,  32'h0,        "save_rest");
        cycle(1, 0, 1, 1, 4'b1111, 1, 9,  32'h9999AAAA, "ld_over_save");
        check_reg(9, "ld_wr_oldwin");

        // back-to-back saves
        cycle(1, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "b2b_a");
        cycle(1, 0, 0, 0, 4'b0000, 1, 20, 32'h20202020, "b2b_b");
        cycle(1, 0, 0, 0, 4'b0000, 0, 0,  32'h0,        "b2b_c");
        for (int r = 0; r < 32; r++) check_reg(r, $sformatf("dir_r%0d", r));

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic sv, rs, ld, w;
            sv = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 2) == 0);
            ld = ($urandom_range(0, 9) == 0);
            w  = ($urandom_range(0, 3) != 0);
            cycle(sv, rs, ld, $urandom_range(0, NWIN-1),
                  ($urandom_range(0, 1) == 0) ? NWIN'(0) : NWIN'($urandom),
                  w, $urandom_range(0, 31), $urandom, "rnd");
            check_reg($urandom_range(0, 31), "rnd_rd");
        end
        for (int r = 0; r < 32; r++) check_reg(r, $sformatf("rnd_end_r%0d", r));

        // reset during an in-flight save: operation is lost
        @(negedge clk);
        save = 1'b1; we = 1'b1; rd = 5'd17; wdata = 32'h77777777; wim = '0;
        #2 reset_n = 1'b0;
        #1;
        save = 1'b0; we = 1'b0;
        model_reset();
        chk("rst2:cwp",  32'(cwp),  32'd0);
        chk("rst2:wovf", 32'(wovf), 32'd0);
        chk("rst2:wunf", 32'(wunf), 32'd0);
        check_all_zero("rst2");
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, 0, 0, 0, 4'b0000, 1, 17, 32'h31313131, "post_rst");
        check_reg(17, "post_rst_r17");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
